servo_angle_ramp: RTL and testbench
===================================

# servo_angle_ramp

Upstream command stage for the 50 kHz-clocked servo PWM generator. It accepts an angle command (degrees) over a valid/ready handshake and converts it to a pulse width in clock ticks using a sequential divider. It then slews the pulse-width output toward that value by at most `STEP_TICKS` per PWM frame. The PWM stage consumes `pulse_ticks` and returns a one-cycle `frame_tick` at each frame wrap.

## Interface
Parameters:
- `MIN_TICKS`, 25: pulse width at 0° (0.5 ms at 50 kHz).
- `MAX_TICKS`, 125: pulse width at `ANGLE_MAX` (2.5 ms).
- `ANGLE_MAX`, 180: largest legal angle; larger commands are clamped to it.
- `STEP_TICKS`, 2: maximum change of `pulse_ticks` per frame; must be ≥ 1.

Ports:
- `clk`, in, 1: clock, 50 kHz.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: angle command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_angle`, in, 8: commanded angle in degrees, unsigned.
- `frame_tick`, in, 1: single-cycle pulse from the PWM stage at frame wrap.
- `pulse_ticks`, out, 10: current pulse width for the PWM stage, registered.
- `at_target`, out, 1: `pulse_ticks` equals the target and no calculation is pending.

## Operation
- Internal values:
  - `SPAN = MAX_TICKS - MIN_TICKS`.
  - `MID = (MIN_TICKS + MAX_TICKS) / 2`, truncated (75 with defaults).
  - Registers `target_ticks` and `cur_ticks` (`cur_ticks` drives `pulse_ticks`).
- FSM states: IDLE, CALC, TRACK.
  - IDLE: `cur_ticks == target_ticks`. `cmd_ready = 1`.
  - CALC: divider running. `cmd_ready = 0`.
  - TRACK: `cur_ticks != target_ticks`. `cmd_ready = 1`.
- Accept: `cmd_valid && cmd_ready` in IDLE or TRACK.
  - The angle is clamped: `a = min(cmd_angle, ANGLE_MAX)`.
  - The product `P = a * SPAN` (16-bit) is latched. Go to CALC.
- CALC: 16-iteration restoring shift-subtract division `Q = floor(P / ANGLE_MAX)`, one iteration per cycle.
  - On the final iteration, `target_ticks <= MIN_TICKS + Q`.
  - Next state is IDLE if the new target equals `cur_ticks`, else TRACK.
- Ramp, on every `frame_tick` in any state (including CALC):
  - If `cur_ticks < target_ticks`: `cur_ticks += min(STEP_TICKS, target_ticks - cur_ticks)`.
  - If `cur_ticks > target_ticks`: the mirror of the above, decrementing.
  - No overshoot.
- During CALC, ramping continues toward the previous `target_ticks`.
- A new command in TRACK replaces the target. `cur_ticks` continues from its present value with no jump.
- TRACK → IDLE on the cycle after `cur_ticks` reaches `target_ticks`.
- `at_target = (state == IDLE)`.
- Arithmetic rules:
  - Unsigned throughout; no overflow with the defaults (`P ≤ 18000`).
  - `pulse_ticks` is always within `[MIN_TICKS, MAX_TICKS]`.

## Timing
- Reset values:
  - State IDLE.
  - `cur_ticks = target_ticks = MID`, so `pulse_ticks = 75`.
  - `cmd_ready = 1`, `at_target = 1`, divider registers cleared.
- Command accepted at cycle N:
  - `cmd_ready = 0` from N+1 through N+16.
  - `target_ticks` is valid at N+17. `cmd_ready = 1` at N+17.
- `pulse_ticks` changes only in the cycle after a `frame_tick`; exactly one step per tick.
- `frame_tick` in the same cycle as the last CALC iteration: the ramp uses the old target.
- `cmd_valid` held without `cmd_ready`: not accepted; the command must be held by the sender.
- Reset asserted mid-CALC or mid-ramp: immediate return to reset values; the pending command is lost.
- Back-to-back commands: the minimum accept spacing is 17 cycles.

## Test plan
- Reset → `pulse_ticks = 75`, `at_target = 1`, `cmd_ready = 1`. Assert reset mid-ramp → same values asynchronously.
- Angle 90 → `target_ticks = 75`; IDLE reached directly after CALC and `at_target` returns to 1 with no frame ticks. Angle 45 → target 50. Angle 1 → target 25 (truncation).
- Angle 180 from reset with `frame_tick` every 1000 cycles → `pulse_ticks` runs 77, 79, …, 125, reached on the 25th tick; `at_target` rises one cycle later.
- Angle 200 → clamped; target 125, identical to 180.
- Ramping up to 125 while at 101 → command angle 0. Expected: `pulse_ticks` holds 101 plus in-CALC ticks, then descends by 2 per frame to 25 without overshoot.
- `cmd_valid` asserted during CALC → `cmd_ready = 0` and the command is ignored until N+17, then accepted.

Source files
------------

// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp
// Command front end for the servo PWM generator. An angle command is clamped,
// scaled to a pulse width with a 16-step restoring divider, and the pulse width
// handed to the PWM stage is slewed toward it by at most STEP_TICKS per frame.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | pulse width equals target, ready for a command
// CALC  | divider running, commands held off, ramp keeps old target
// TRACK | pulse width slewing toward target, ready for a command
module servo_angle_ramp #(
    parameter int MIN_TICKS  = 25,
    parameter int MAX_TICKS  = 125,
    parameter int ANGLE_MAX  = 180,
    parameter int STEP_TICKS = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_angle,
    input  logic       frame_tick,
    output logic [9:0] pulse_ticks,
    output logic       at_target
);

    localparam int SPAN = MAX_TICKS - MIN_TICKS;
    localparam int MID  = (MIN_TICKS + MAX_TICKS) / 2;

    localparam logic [9:0]  MIN_T  = 10'(MIN_TICKS);
    localparam logic [9:0]  MID_T  = 10'(MID);
    localparam logic [9:0]  STEP_T = 10'(STEP_TICKS);
    localparam logic [7:0]  AMAX_A = 8'(ANGLE_MAX);
    localparam logic [8:0]  DIV9   = 9'(ANGLE_MAX);
    localparam logic [15:0] SPAN16 = 16'(SPAN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [9:0]  target_ticks;
    logic [9:0]  cur_ticks;
    logic [9:0]  cur_next;

    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so after 16 steps this register holds the quotient.
    logic [15:0] shreg;
    logic [7:0]  rem;
    logic [3:0]  iter_cnt;

    logic [7:0]  angle_clamped;
    logic [15:0] product;
    logic [8:0]  rem_shift;
    logic        q_bit;
    logic [9:0]  tgt_calc;
    logic        load;
    logic        calc_done;

    // Clamp the command angle and form the scaled product for the divider.
    always_comb begin
        angle_clamped = (cmd_angle > AMAX_A) ? AMAX_A : cmd_angle;
        product       = 16'(angle_clamped) * SPAN16;
    end

    // One restoring division step; the remainder stays below ANGLE_MAX.
    always_comb begin
        rem_shift = {rem, shreg[15]};
        q_bit     = (rem_shift >= DIV9);
        tgt_calc  = MIN_T + 10'({shreg[14:0], q_bit});
    end

    // Slew toward the registered target on each frame, clipping the last step.
    always_comb begin
        cur_next = cur_ticks;
        if (frame_tick) begin
            if (cur_ticks < target_ticks) begin
                if ((target_ticks - cur_ticks) > STEP_T) begin
                    cur_next = cur_ticks + STEP_T;
                end else begin
                    cur_next = target_ticks;
                end
            end else if (cur_ticks > target_ticks) begin
                if ((cur_ticks - target_ticks) > STEP_T) begin
                    cur_next = cur_ticks - STEP_T;
                end else begin
                    cur_next = target_ticks;
                end
            end
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        calc_done  = 1'b0;
        cmd_ready  = 1'b0;
        at_target  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                at_target = 1'b1;
                if (cmd_valid) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (iter_cnt == 4'd0) begin
                    calc_done = 1'b1;
                    // Compare against the post-ramp value so a frame landing on
                    // the final step cannot leave IDLE with a stale match.
                    state_next = (tgt_calc == cur_next) ? IDLE : TRACK;
                end
            end
            TRACK: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load       = 1'b1;
                    state_next = CALC;
                end else if (cur_ticks == target_ticks) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pulse width and target registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_ticks    <= MID_T;
            target_ticks <= MID_T;
        end else begin
            cur_ticks <= cur_next;
            if (calc_done) begin
                target_ticks <= tgt_calc;
            end
        end
    end

    // Divider datapath: load on accept, then one step per CALC cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg    <= 16'd0;
            rem      <= 8'd0;
            iter_cnt <= 4'd0;
        end else if (load) begin
            shreg    <= product;
            rem      <= 8'd0;
            iter_cnt <= 4'd15;
        end else if (state == CALC) begin
            shreg <= {shreg[14:0], q_bit};
            rem   <= 8'(q_bit ? (rem_shift - DIV9) : rem_shift);
            if (iter_cnt != 4'd0) begin
                iter_cnt <= iter_cnt - 4'd1;
            end
        end
    end

    assign pulse_ticks = cur_ticks;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp: handshake timing, divider results,
// frame-by-frame ramp values, clamping, reversal and asynchronous reset.
module tb_servo_angle_ramp;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_angle = 8'd0;
    logic       frame_tick = 1'b0;
    logic       cmd_ready;
    logic       at_target;
    logic [9:0] pulse_ticks;

    int n_cmp = 0;
    int n_bad = 0;

    servo_angle_ramp dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_angle  (cmd_angle),
        .frame_tick (frame_tick),
        .pulse_ticks(pulse_ticks),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    // Present a command for one cycle; returns at the negedge after the accept edge.
    task automatic issue_cmd(input logic [7:0] ang);
        cmd_angle = ang;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL reset_pulse got %0d want 75", pulse_ticks); end
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL reset_at_target got %b want 1", at_target); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL post_reset_pulse got %0d want 75", pulse_ticks); end
    endtask

    task automatic test_calc_timing();
        int bad = 0;
        issue_cmd(8'd90);
        for (int i = 0; i < 16; i++) begin
            if (cmd_ready !== 1'b0 || at_target !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL calc_busy_window bad_cycles %0d want 0", bad); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL calc_ready_n17 got %b want 1", cmd_ready); end
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL angle90_direct_idle got %b want 1", at_target); end
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL angle90_pulse got %0d want 75", pulse_ticks); end
    endtask

    task automatic test_angle_45();
        int bad = 0;
        int exp_v = 75;
        issue_cmd(8'd45);
        idle_cycles(16);
        n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL angle45_track got %b want 0", at_target); end
        for (int k = 0; k < 13; k++) begin
            frame();
            exp_v = (exp_v - 2 < 50) ? 50 : exp_v - 2;
            if (pulse_ticks !== 10'(exp_v)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL angle45_ramp bad_steps %0d want 0", bad); end
        n_cmp++; if (pulse_ticks !== 10'd50) begin n_bad++; $display("FAIL angle45_final got %0d want 50", pulse_ticks); end
        n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL angle45_at_target_early got %b want 0", at_target); end
        @(negedge clk);
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL angle45_at_target_late got %b want 1", at_target); end
    endtask

    task automatic test_angle_1();
        int bad = 0;
        int exp_v = 50;
        issue_cmd(8'd1);
        idle_cycles(16);
        for (int k = 0; k < 14; k++) begin
            frame();
            exp_v = (exp_v - 2 < 25) ? 25 : exp_v - 2;
            if (pulse_ticks !== 10'(exp_v)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL angle1_ramp bad_steps %0d want 0", bad); end
        n_cmp++; if (pulse_ticks !== 10'd25) begin n_bad++; $display("FAIL angle1_final got %0d want 25", pulse_ticks); end
        @(negedge clk);
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL angle1_at_target got %b want 1", at_target); end
    endtask

    task automatic test_full_sweep();
        int bad_hold = 0;
        int bad_step = 0;
        apply_reset();
        issue_cmd(8'd180);
        idle_cycles(16);
        for (int k = 1; k <= 25; k++) begin
            idle_cycles(999);
            if (pulse_ticks !== 10'(75 + 2 * (k - 1))) bad_hold++;
            frame();
            if (pulse_ticks !== 10'(75 + 2 * k) || at_target !== 1'b0) bad_step++;
        end
        n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL sweep_hold bad %0d want 0", bad_hold); end
        n_cmp++; if (bad_step != 0) begin n_bad++; $display("FAIL sweep_step bad %0d want 0", bad_step); end
        @(negedge clk);
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL sweep_at_target got %b want 1", at_target); end
        n_cmp++; if (pulse_ticks !== 10'd125) begin n_bad++; $display("FAIL sweep_final got %0d want 125", pulse_ticks); end
    endtask

    task automatic test_clamp_200();
        apply_reset();
        issue_cmd(8'd200);
        idle_cycles(16);
        for (int k = 1; k <= 24; k++) begin
            frame();
            idle_cycles(2);
        end
        n_cmp++; if (pulse_ticks !== 10'd123) begin n_bad++; $display("FAIL clamp_tick24 got %0d want 123", pulse_ticks); end
        frame();
        n_cmp++; if (pulse_ticks !== 10'd125) begin n_bad++; $display("FAIL clamp_tick25 got %0d want 125", pulse_ticks); end
        frame();
        n_cmp++; if (pulse_ticks !== 10'd125) begin n_bad++; $display("FAIL clamp_no_overshoot got %0d want 125", pulse_ticks); end
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL clamp_at_target got %b want 1", at_target); end
    endtask

    task automatic test_reverse();
        int bad_ready = 0;
        int bad_step = 0;
        int exp_v;
        apply_reset();
        issue_cmd(8'd180);
        idle_cycles(16);
        for (int k = 0; k < 13; k++) frame();
        n_cmp++; if (pulse_ticks !== 10'd101) begin n_bad++; $display("FAIL reverse_start got %0d want 101", pulse_ticks); end
        issue_cmd(8'd0);
        for (int i = 0; i < 16; i++) begin
            if (cmd_ready !== 1'b0) bad_ready++;
            if (i == 3) begin
                n_cmp++; if (pulse_ticks !== 10'd101) begin n_bad++; $display("FAIL reverse_hold_in_calc got %0d want 101", pulse_ticks); end
            end
            frame_tick = (i == 3 || i == 15);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        n_cmp++; if (bad_ready != 0) begin n_bad++; $display("FAIL reverse_calc_ready bad %0d want 0", bad_ready); end
        n_cmp++; if (pulse_ticks !== 10'd105) begin n_bad++; $display("FAIL reverse_calc_ticks got %0d want 105", pulse_ticks); end
        n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL reverse_track got %b want 0", at_target); end
        exp_v = 105;
        for (int k = 0; k < 41; k++) begin
            frame();
            exp_v = (exp_v - 2 < 25) ? 25 : exp_v - 2;
            if (pulse_ticks !== 10'(exp_v) || pulse_ticks < 10'd25) bad_step++;
        end
        n_cmp++; if (bad_step != 0) begin n_bad++; $display("FAIL reverse_descent bad %0d want 0", bad_step); end
        n_cmp++; if (pulse_ticks !== 10'd25) begin n_bad++; $display("FAIL reverse_final got %0d want 25", pulse_ticks); end
        @(negedge clk);
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL reverse_at_target got %b want 1", at_target); end
    endtask

    task automatic test_hold_during_calc();
        int bad = 0;
        apply_reset();
        issue_cmd(8'd45);
        cmd_angle = 8'd180;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_ready_low bad %0d want 0", bad); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready_n17 got %b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_accepted got %b want 0", cmd_ready); end
        idle_cycles(16);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL hold_second_done got %b want 1", cmd_ready); end
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL hold_pulse got %0d want 75", pulse_ticks); end
        frame();
        n_cmp++; if (pulse_ticks !== 10'd77) begin n_bad++; $display("FAIL hold_target_180 got %0d want 77", pulse_ticks); end
    endtask

    task automatic test_reset_mid_calc();
        issue_cmd(8'd0);
        idle_cycles(5);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL rst_calc_pulse got %0d want 75", pulse_ticks); end
        n_cmp++; if (cmd_ready !== 1'b1 || at_target !== 1'b1) begin n_bad++; $display("FAIL rst_calc_flags got %b%b want 11", cmd_ready, at_target); end
        @(negedge clk);
        resetn = 1'b1;
        idle_cycles(20);
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL rst_calc_lost_at_target got %b want 1", at_target); end
        frame();
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL rst_calc_lost_pulse got %0d want 75", pulse_ticks); end
    endtask

    task automatic test_reset_mid_ramp();
        issue_cmd(8'd180);
        idle_cycles(16);
        for (int k = 0; k < 5; k++) frame();
        n_cmp++; if (pulse_ticks !== 10'd85) begin n_bad++; $display("FAIL rst_ramp_pre got %0d want 85", pulse_ticks); end
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (pulse_ticks !== 10'd75) begin n_bad++; $display("FAIL rst_ramp_pulse got %0d want 75", pulse_ticks); end
        n_cmp++; if (cmd_ready !== 1'b1 || at_target !== 1'b1) begin n_bad++; $display("FAIL rst_ramp_flags got %b%b want 11", cmd_ready, at_target); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_calc_timing();
        test_angle_45();
        test_angle_1();
        test_full_sweep();
        test_clamp_200();
        test_reverse();
        test_hold_during_calc();
        test_reset_mid_calc();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
